rst_seq: RTL and testbench

- Parametrised reset sequencer that sits between the board/bench reset and the RV64I core's subsystems.
- Async-asserts all domain resets at once and synchronously de-asserts them.
- After a programmable hold, releases N reset domains in a fixed order, one every GAP_CYCLES (e.g. memories, then core, then peripherals).
- Adds a software-requested re-reset path and reports completion and reset cause.

---
 rtl/rst_seq_pkg.sv | 17 +
 rtl/rst_sync.sv | 23 ++
 rtl/rst_seq.sv | 126 ++++++++++++
 tb/tb_rst_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } seq_state_e;

  localparam logic [1:0] CAUSE_EXT  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Async-assert / sync-deassert reset synchroniser, SYNC_STAGES deep.
module rst_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Clear all stages at once on reset, then shift ones in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds every domain in reset, then releases them
// lowest index first with a fixed gap, and reports the reset cause.
//
// state      | meaning
// ST_ASSERT  | all domains held; counting the hold time once synchronised
// ST_RELEASE | at least one domain out; counting the gap to the next one
// ST_DONE    | every domain released; waiting for soft request or rst_n
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned N_DOMAINS   = 3,
  parameter int unsigned HOLD_CYCLES = 10,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 soft_rst_req,
  output logic [N_DOMAINS-1:0] domain_rst_n,
  output logic                 seq_done,
  output logic [1:0]           rst_cause
);

  localparam int unsigned CNT_MAX = max_u(HOLD_CYCLES, GAP_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [N_DOMAINS-1:0] DOM_LSB = N_DOMAINS'(1);

  logic                 rst_sync_n;
  seq_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_DOMAINS-1:0] dom_q, dom_d;
  logic                 done_q, done_d;
  logic [1:0]           cause_q, cause_d;

  logic                 soft_take;
  logic                 release_now;
  logic [N_DOMAINS-1:0] rel_next;
  logic                 last_release;

  rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_sync_n (rst_sync_n)
  );

  // Released domains form a thermometer code, so the next release is
  // simply one more low-order bit; domain order is fixed by construction.
  assign soft_take    = soft_rst_req & rst_sync_n;
  assign rel_next     = (dom_q << 1) | DOM_LSB;
  assign last_release = &rel_next;
  assign release_now  = ((state_q == ST_ASSERT) && rst_sync_n && (cnt_q == HOLD_TC)) ||
                        ((state_q == ST_RELEASE) && (cnt_q == GAP_TC));

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      dom_q   <= '0;
      done_q  <= 1'b0;
      cause_q <= CAUSE_EXT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dom_q   <= dom_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  // Next state and counter; a soft request restarts from the hold phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (soft_take) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (!rst_sync_n) begin
            cnt_d = '0;
          end else if (release_now) begin
            cnt_d   = '0;
            state_d = last_release ? ST_DONE : ST_RELEASE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (release_now) begin
            cnt_d = '0;
            if (last_release) state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    dom_d   = dom_q;
    done_d  = done_q;
    cause_d = cause_q;
    if (soft_take) begin
      dom_d   = '0;
      done_d  = 1'b0;
      cause_d = CAUSE_SOFT;
    end else if (release_now) begin
      dom_d  = rel_next;
      done_d = last_release;
    end
  end

  assign domain_rst_n = dom_q;
  assign seq_done     = done_q;
  assign rst_cause    = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: a default instance and a minimal-parameter instance
// driven side by side, checked against an edge-count release model.
module tb_rst_seq;

  localparam int A_S = 2, A_N = 3, A_H = 10, A_G = 4;
  localparam int B_S = 3, B_N = 1, B_H = 1,  B_G = 1;

  logic           clk    = 1'b0;
  logic           rst_n  = 1'b0;
  logic           soft_a = 1'b0;
  logic           soft_b = 1'b0;
  logic [A_N-1:0] dom_a;
  logic           done_a;
  logic [1:0]     cause_a;
  logic [B_N-1:0] dom_b;
  logic           done_b;
  logic [1:0]     cause_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rst_seq #(.SYNC_STAGES(A_S), .N_DOMAINS(A_N), .HOLD_CYCLES(A_H), .GAP_CYCLES(A_G)) u_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .soft_rst_req (soft_a),
    .domain_rst_n (dom_a),
    .seq_done     (done_a),
    .rst_cause    (cause_a)
  );

  rst_seq #(.SYNC_STAGES(B_S), .N_DOMAINS(B_N), .HOLD_CYCLES(B_H), .GAP_CYCLES(B_G)) u_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .soft_rst_req (soft_b),
    .domain_rst_n (dom_b),
    .seq_done     (done_b),
    .rst_cause    (cause_b)
  );

  // Reference model: e = edges since rst_n rose, anc = edge the current
  // sequence is anchored to (-1 = none); domain k is out at anc+H+k*G.
  int         e_a = 0, anc_a = -1, e_b = 0, anc_b = -1;
  logic [1:0] mc_a = 2'b01, mc_b = 2'b01;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_a <= 0; anc_a <= -1; mc_a <= 2'b01;
      e_b <= 0; anc_b <= -1; mc_b <= 2'b01;
    end else begin
      e_a <= e_a + 1;
      if (e_a + 1 == A_S) anc_a <= A_S;
      if (soft_a && e_a >= A_S) begin anc_a <= e_a + 1; mc_a <= 2'b10; end
      e_b <= e_b + 1;
      if (e_b + 1 == B_S) anc_b <= B_S;
      if (soft_b && e_b >= B_S) begin anc_b <= e_b + 1; mc_b <= 2'b10; end
    end
  end

  function automatic logic [7:0] exp_dom(input int e, input int anc, input int n,
                                         input int h, input int g);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < n; k++)
      if (anc >= 0 && e >= anc + h + k * g) r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] exp_done(input int e, input int anc, input int n,
                                          input int h, input int g);
    return {7'b0, (anc >= 0 && e >= anc + h + (n - 1) * g)};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_model();
    check("a.dom",   {5'b0, dom_a},   exp_dom(e_a, anc_a, A_N, A_H, A_G));
    check("a.done",  {7'b0, done_a},  exp_done(e_a, anc_a, A_N, A_H, A_G));
    check("a.cause", {6'b0, cause_a}, {6'b0, mc_a});
    check("b.dom",   {7'b0, dom_b},   exp_dom(e_b, anc_b, B_N, B_H, B_G));
    check("b.done",  {7'b0, done_b},  exp_done(e_b, anc_b, B_N, B_H, B_G));
    check("b.cause", {6'b0, cause_b}, {6'b0, mc_b});
  endtask

  task automatic cyc();
    @(negedge clk);
    check_model();
  endtask

  // Cycles after rst_n rises, with fixed release edges for both instances.
  task automatic power_up(input int n);
    for (int i = 1; i <= n; i++) begin
      cyc();
      if (i == 11) check("pu.a11", {5'b0, dom_a}, 8'h0);
      if (i == 12) check("pu.a12", {5'b0, dom_a}, 8'h1);
      if (i == 15) check("pu.a15", {5'b0, dom_a}, 8'h1);
      if (i == 16) check("pu.a16", {5'b0, dom_a}, 8'h3);
      if (i == 19) check("pu.done19", {7'b0, done_a}, 8'h0);
      if (i == 20) begin
        check("pu.a20", {5'b0, dom_a}, 8'h7);
        check("pu.done20", {7'b0, done_a}, 8'h1);
        check("pu.cause", {6'b0, cause_a}, 8'h1);
      end
      if (i == 3) check("pu.b3", {7'b0, dom_b}, 8'h0);
      if (i == 4) begin
        check("pu.b4", {7'b0, dom_b}, 8'h1);
        check("pu.bdone4", {7'b0, done_b}, 8'h1);
      end
    end
  endtask

  // One-cycle soft request on both instances, then len cycles of follow-up.
  task automatic soft_seq(input int len);
    soft_a = 1'b1;
    soft_b = 1'b1;
    cyc();
    soft_a = 1'b0;
    soft_b = 1'b0;
    check("sr.a0", {5'b0, dom_a}, 8'h0);
    check("sr.done0", {7'b0, done_a}, 8'h0);
    check("sr.cause", {6'b0, cause_a}, 8'h2);
    check("sr.b0", {7'b0, dom_b}, 8'h0);
    check("sr.bcause", {6'b0, cause_b}, 8'h2);
    for (int i = 1; i <= len; i++) begin
      cyc();
      if (i == 1)  check("sr.b1", {7'b0, dom_b}, 8'h1);
      if (i == 9)  check("sr.a9", {5'b0, dom_a}, 8'h0);
      if (i == 10) check("sr.a10", {5'b0, dom_a}, 8'h1);
      if (i == 14) check("sr.a14", {5'b0, dom_a}, 8'h3);
      if (i == 18) begin
        check("sr.a18", {5'b0, dom_a}, 8'h7);
        check("sr.done18", {7'b0, done_a}, 8'h1);
      end
    end
  endtask

  initial begin
    int low_left;

    // Power-on reset held for 100 ns.
    repeat (10) begin
      cyc();
      check("por.dom", {5'b0, dom_a}, 8'h0);
      check("por.cause", {6'b0, cause_a}, 8'h1);
    end
    rst_n = 1'b1;
    power_up(22);

    // Soft request in DONE, then again mid-release.
    soft_seq(18);
    soft_seq(11);
    check("mid.a", {5'b0, dom_a}, 8'h1);
    soft_seq(18);

    // Async rst_n pulse between clock edges during the hold.
    soft_seq(4);
    #2 rst_n = 1'b0;
    #1;
    check("async.dom", {5'b0, dom_a}, 8'h0);
    check("async.done", {7'b0, done_a}, 8'h0);
    check("async.cause", {6'b0, cause_a}, 8'h1);
    check("async.bdom", {7'b0, dom_b}, 8'h0);
    check_model();
    #1 rst_n = 1'b1;
    power_up(22);

    // Soft request held high for 30 cycles from DONE.
    soft_a = 1'b1;
    soft_b = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      check("hold.a", {5'b0, dom_a}, 8'h0);
      check("hold.b", {7'b0, dom_b}, 8'h0);
    end
    soft_a = 1'b0;
    soft_b = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (i == 1)  check("hold.b1", {7'b0, dom_b}, 8'h1);
      if (i == 9)  check("hold.a9", {5'b0, dom_a}, 8'h0);
      if (i == 10) check("hold.a10", {5'b0, dom_a}, 8'h1);
    end

    // Random soft requests and rst_n drops against the model.
    low_left = 0;
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (low_left > 0) begin
        low_left--;
        if (low_left == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        low_left = $urandom_range(1, 3);
      end
      soft_a = ($urandom_range(0, 29) == 0);
      soft_b = ($urandom_range(0, 19) == 0);
    end
    rst_n  = 1'b1;
    soft_a = 1'b0;
    soft_b = 1'b0;
    repeat (25) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
